mips_cpu_store: RTL and testbench

Store-path unit of the Harvard MIPS CPU, the write-side counterpart of the load formatter.
- Takes SB/SH/SW from execute, checks alignment, and steers register bytes onto data-memory byte lanes.
- Drives a waitrequest-style data-memory write handshake, stalling the CPU until the write is accepted.
- Lane convention: big-endian byte at address offset k maps to bus lane k (bits 8k+7:8k). SW writes {rt[7:0],rt[15:8],rt[23:16],rt[31:24]}.

---
 rtl/mips_cpu_pkg.sv | 11 +
 rtl/mips_cpu_store_format.sv | 35 +++
 rtl/mips_cpu_store.sv | 133 +++++++++++++
 tb/tb_mips_cpu_store.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: opcodes and store-path state shared by the CPU memory units
package mips_cpu_pkg;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} store_state_e;
    // Expand a 4-bit lane enable into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/mips_cpu_store_format.sv
// mips_cpu_store_format: steers register bytes onto big-endian memory lanes
// Ports:
//   op_i       store opcode (instruction[31:26])
//   off_i      byte offset within the word (addr[1:0])
//   rt_i       store source register
//   data_o     lane-formatted write data, disabled lanes zero
//   be_o       per-lane byte enable
//   store_o    opcode is SB/SH/SW
//   misalign_o SH on odd address or SW not word aligned
module mips_cpu_store_format
    import mips_cpu_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rt_i,
    output logic [31:0] data_o,
    output logic [3:0]  be_o,
    output logic        store_o,
    output logic        misalign_o
);
    logic sb, sh, sw;
    logic [4:0] sh_amt;
    assign sb = op_i == OP_SB;
    assign sh = op_i == OP_SH;
    assign sw = op_i == OP_SW;
    assign sh_amt = {off_i, 3'b000};
    assign store_o = sb | sh | sw;
    assign misalign_o = (sh & off_i[0]) | (sw & |off_i);
    // Lane k holds the byte at address offset k, so the MSB of a halfword lands on the lower lane.
    assign data_o = sw ? {rt_i[7:0], rt_i[15:8], rt_i[23:16], rt_i[31:24]}
                  : sh ? {16'b0, rt_i[7:0], rt_i[15:8]} << sh_amt
                  : sb ? {24'b0, rt_i[7:0]} << sh_amt
                  : '0;
    assign be_o = sw ? 4'b1111 : sh ? 4'b0011 << off_i : sb ? 4'b0001 << off_i : 4'b0000;
endmodule

// File: rtl/mips_cpu_store.sv
// mips_cpu_store: store path with alignment check and waitrequest write handshake
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   instr_valid           store request qualifier from execute
//   instruction, addr     opcode source (bits 31:26) and effective address
//   rt_data               store source register
//   busy, done, addr_err  stall request, commit pulse, misalignment pulse
//   mem_*                 data-memory bus (waitrequest style)
// Build option: MIPS_STORE_RMW_EN turns SB/SH into read-merge-write for memories without byte enables.
module mips_cpu_store
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_data,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata
);
    store_state_e      state_q;
    logic              busy_q, done_q, err_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q, fdata;
    logic [3:0]        be_q, fbe;
    logic              fstore, fmis;
    logic [5:0]        op;
    assign op = instruction[31:26];
    mips_cpu_store_format u_fmt (
        .op_i(op), .off_i(addr[1:0]), .rt_i(rt_data),
        .data_o(fdata), .be_o(fbe), .store_o(fstore), .misalign_o(fmis)
    );
`ifdef MIPS_STORE_RMW_EN
    logic       rd_q, pend_q;
    logic [3:0] mask_q;
    logic       unused_ok;
    assign unused_ok = ^instruction[25:0];
    assign mem_read = rd_q;
`else
    logic unused_ok;
    assign unused_ok = ^{instruction[25:0], mem_readdata};
    assign mem_read = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MIPS_STORE_RMW_EN
            rd_q    <= 1'b0;
            pend_q  <= 1'b0;
            mask_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (instr_valid && fstore) begin
                    if (fmis) begin
                        err_q <= 1'b1;
                    end else begin
                        addr_q <= {addr[ADDR_W-1:2], 2'b00};
                        data_q <= fdata;
                        busy_q <= 1'b1;
`ifdef MIPS_STORE_RMW_EN
                        mask_q <= fbe;
                        if (op != OP_SW) begin
                            state_q <= ST_READ;
                            rd_q    <= 1'b1;
                            pend_q  <= 1'b0;
                            be_q    <= 4'b1111;
                        end else begin
                            state_q <= ST_WRITE;
                            wr_q    <= 1'b1;
                            be_q    <= fbe;
                        end
`else
                        state_q <= ST_WRITE;
                        wr_q    <= 1'b1;
                        be_q    <= fbe;
`endif
                    end
                end
`ifdef MIPS_STORE_RMW_EN
                // Read data is returned the cycle after the read is accepted; merge it then.
                ST_READ: if (!pend_q) begin
                    if (!mem_waitrequest) begin
                        rd_q   <= 1'b0;
                        pend_q <= 1'b1;
                    end
                end else begin
                    data_q  <= (data_q & lane_mask(mask_q)) | (mem_readdata & ~lane_mask(mask_q));
                    pend_q  <= 1'b0;
                    wr_q    <= 1'b1;
                    be_q    <= 4'b1111;
                    state_q <= ST_WRITE;
                end
`endif
                ST_WRITE: if (!mem_waitrequest) begin
                    state_q <= ST_IDLE;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    be_q    <= '0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign busy           = busy_q;
    assign done           = done_q;
    assign addr_err       = err_q;
    assign mem_address    = addr_q;
    assign mem_write      = wr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = data_q;
endmodule

// File: tb/tb_mips_cpu_store.sv
// tb_mips_cpu_store: scoreboard bench for the store path (default build)
module tb_mips_cpu_store;
    typedef struct packed {
        logic        err;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [7:0]  wcyc;
    } exp_t;
    logic        clk = 0, reset = 1, instr_valid = 0, mem_waitrequest = 0;
    logic [31:0] instruction = 0, addr = 0, rt_data = 0, mem_readdata = 32'h12345678;
    logic        busy, done, addr_err, mem_write, mem_read;
    logic [31:0] mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;
    exp_t        sb[$];
    int          nchk = 0, nfail = 0, wcnt = 0;
    mips_cpu_store #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
        .addr(addr), .rt_data(rt_data), .busy(busy), .done(done), .addr_err(addr_err),
        .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            wcnt = 0;
        end else begin
            if (done || addr_err) chk("done_err_exclusive", 128'(done & addr_err), 128'(0));
            if (mem_write) begin
                wcnt++;
                if (sb.size() == 0) chk("spurious_write", 128'(1), 128'(0));
                else begin
                    e = sb[0];
                    chk("write_bus", {e.err, mem_address, mem_writedata, mem_byteenable, busy, mem_read},
                        {1'b0, e.a, e.d, e.be, 1'b1, 1'b0});
                end
            end
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
                else begin
                    e = sb.pop_front();
                    chk("done_cycles", {e.err, 8'(wcnt)}, {1'b0, e.wcyc});
                end
                wcnt = 0;
            end
            if (addr_err) begin
                if (sb.size() == 0) chk("unexpected_addr_err", 128'(1), 128'(0));
                else begin
                    e = sb.pop_front();
                    chk("addr_err", {e.err, mem_write, busy}, 3'b100);
                end
            end
        end
    end
    task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r,
                         input int waits, input exp_t e);
        sb.push_back(e);
        instruction = {op, 26'd0};
        addr = a;
        rt_data = r;
        instr_valid = 1;
        mem_waitrequest = waits > 0;
        @(posedge clk);
        #1 instr_valid = 0;
        instruction = 0;
        repeat (waits) @(posedge clk);
        #1 mem_waitrequest = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask
    initial begin
        #12;
        chk("reset_state", {busy, done, addr_err, mem_write, mem_read, mem_byteenable, mem_address, mem_writedata}, 128'(0));
        reset = 0;
        @(posedge clk);
        #1;
        store(6'b101011, 32'h100, 32'h11223344, 0, '{1'b0, 32'h100, 32'h44332211, 4'b1111, 8'd1});
        store(6'b101000, 32'h203, 32'hAABBCCDD, 0, '{1'b0, 32'h200, 32'hDD000000, 4'b1000, 8'd1});
        store(6'b101000, 32'h201, 32'hAABBCCDD, 1, '{1'b0, 32'h200, 32'h0000DD00, 4'b0010, 8'd2});
        store(6'b101001, 32'h302, 32'h0000BEEF, 3, '{1'b0, 32'h300, 32'hEFBE0000, 4'b1100, 8'd4});
        store(6'b101001, 32'h300, 32'h1234BEEF, 0, '{1'b0, 32'h300, 32'h0000EFBE, 4'b0011, 8'd1});
        store(6'b101001, 32'h301, 32'h0000BEEF, 0, '{1'b1, 32'h0, 32'h0, 4'b0, 8'd0});
        store(6'b101011, 32'h402, 32'h11223344, 0, '{1'b1, 32'h0, 32'h0, 4'b0, 8'd0});
        instruction = {6'b100011, 26'd0};
        addr = 32'h600;
        rt_data = 32'h55667788;
        instr_valid = 1;
        repeat (2) @(posedge clk);
        #1 instr_valid = 0;
        chk("lw_ignored", {busy, mem_write, mem_byteenable, mem_address, mem_writedata}, {2'b00, 4'h0, 32'h300, 32'h0000EFBE});
        @(posedge clk);
        #1;
        sb.push_back('{1'b0, 32'h500, 32'h0DF0FECA, 4'b1111, 8'd0});
        instruction = {6'b101011, 26'd0};
        addr = 32'h500;
        rt_data = 32'hCAFEF00D;
        instr_valid = 1;
        mem_waitrequest = 1;
        @(posedge clk);
        #1 instr_valid = 0;
        @(posedge clk);
        #2 reset = 1;
        #1 chk("reset_abort", {mem_write, busy, mem_byteenable, done}, 7'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 0;
        mem_waitrequest = 0;
        @(posedge clk);
        #1;
        store(6'b101011, 32'h104, 32'hDEADBEEF, 0, '{1'b0, 32'h104, 32'hEFBEADDE, 4'b1111, 8'd1});
        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
